usb_rx_packer: RTL and testbench

Parametrised successor to the single-byte FT245-style USB FIFO reader. It qualifies RXF#, drives RD# with programmable strobe and precharge timing, and packs BYTES_PER_WORD bytes into one word. Completed words go into an internal first-word-fall-through output FIFO with a valid/ready handshake, so back-pressure is handled without a hold input. It sits between the USB FIFO pins and the downstream frame/command logic.

---
 rtl/usb_rx_packer.sv | 191 +++++++++++++++++++
 tb/tb_usb_rx_packer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packer.sv
// FT245-style USB FIFO reader: qualifies RXF#, times RD# strobes, packs bytes
// into words and queues them in a first-word-fall-through output FIFO.
module usb_rx_packer #(
    parameter int BYTES_PER_WORD   = 2,
    parameter int RXF_SYNC         = 2,
    parameter int RD_LOW_CYCLES    = 4,
    parameter int PRECHARGE_CYCLES = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int LITTLE_ENDIAN    = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [7:0]                            data,
    input  logic                                  rxf,
    output logic                                  rd,
    input  logic                                  flush,
    output logic [8*BYTES_PER_WORD-1:0]           out_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]   out_bytes,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic [2:0]                            state
);

    localparam int WW   = 8 * BYTES_PER_WORD;
    localparam int BW   = $clog2(BYTES_PER_WORD + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (RXF_SYNC > RD_LOW_CYCLES)
                        ? ((RXF_SYNC > PRECHARGE_CYCLES) ? RXF_SYNC : PRECHARGE_CYCLES)
                        : ((RD_LOW_CYCLES > PRECHARGE_CYCLES) ? RD_LOW_CYCLES : PRECHARGE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_SYNC   = TW'(RXF_SYNC);
    localparam logic [BW-1:0] B_ONE    = BW'(1);
    localparam logic [BW-1:0] LAST_IDX = BW'(BYTES_PER_WORD - 1);
    localparam logic [BW-1:0] FULL_CNT = BW'(BYTES_PER_WORD);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] P_ONE    = PW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUAL   = 3'd1,
        STROBE = 3'd2,
        SAMPLE = 3'd3,
        PRECHG = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   word_q, word_d;
    logic            pend_q, pend_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic [WW-1:0]   data_mem  [FIFO_DEPTH];
    logic [BW-1:0]   bytes_mem [FIFO_DEPTH];

    logic            has_space, qualified, serve, push, pop;
    logic [BW-1:0]   lane;
    logic [WW-1:0]   word_cap, push_word;
    logic [BW-1:0]   push_bytes;

    assign has_space = (count_q < DEPTH_C);
    assign qualified = ((int'(cnt_q) + 1) >= RXF_SYNC);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= 1'b1;
            idx_q    <= '0;
            word_q   <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + P_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= push_word;
            bytes_mem[wr_ptr_q] <= push_bytes;
        end
    end

    // Next-state logic; cnt_q is the qualify, strobe or precharge timer by state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, QUAL: begin
                if (rxf) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (qualified && has_space && !pend_q) begin
                    state_d = (RD_LOW_CYCLES == 1) ? SAMPLE : STROBE;
                    cnt_d   = '0;
                end else begin
                    state_d = QUAL;
                    cnt_d   = qualified ? T_SYNC : cnt_q + T_ONE;
                end
            end
            STROBE: begin
                if (int'(cnt_q) >= RD_LOW_CYCLES - 2) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + T_ONE;
                end
            end
            SAMPLE: begin
                state_d = PRECHG;
                cnt_d   = '0;
            end
            PRECHG: begin
                if (int'(cnt_q) >= PRECHARGE_CYCLES - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + T_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output/action logic: strobe level, byte capture, flush service, FIFO push
    always_comb begin
        rd_d       = !((state_d == STROBE) || (state_d == SAMPLE));
        serve      = ((state_q == IDLE) || (state_q == QUAL)) && pend_q && has_space;
        pend_d     = flush || (pend_q && !serve);
        lane       = (LITTLE_ENDIAN != 0) ? idx_q : (LAST_IDX - idx_q);
        word_cap   = word_q;
        word_cap[{lane, 3'b000} +: 8] = data;
        push       = 1'b0;
        push_word  = word_cap;
        push_bytes = FULL_CNT;
        idx_d      = idx_q;
        word_d     = word_q;
        if (state_q == SAMPLE) begin
            if (idx_q == LAST_IDX) begin
                push   = 1'b1;
                idx_d  = '0;
                word_d = '0;
            end else begin
                idx_d  = idx_q + B_ONE;
                word_d = word_cap;
            end
        end else if (serve) begin
            push       = (idx_q != '0);
            push_word  = word_q;
            push_bytes = idx_q;
            idx_d      = '0;
            word_d     = '0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
    end

    assign rd         = rd_q;
    assign out_data   = out_valid ? data_mem[rd_ptr_q]  : '0;
    assign out_bytes  = out_valid ? bytes_mem[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_usb_rx_packer.sv
// Directed bench for usb_rx_packer: a little-endian and a big-endian instance
// share one modelled USB FIFO that advances on each RD# rising edge.
module tb_usb_rx_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        rxf;
    logic        flush;
    logic        out_ready;
    logic        glitch;

    logic        rd, be_rd;
    logic [15:0] out_data, be_out_data;
    logic [1:0]  out_bytes, be_out_bytes;
    logic        out_valid, be_out_valid;
    logic [2:0]  fifo_count, be_fifo_count;
    logic [2:0]  state, be_state;

    logic [7:0]  src [16];
    int unsigned src_n;
    int unsigned src_base;
    int unsigned rd_rises = 0;
    int unsigned pos;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge rd) rd_rises <= rd_rises + 1;

    assign pos  = rd_rises - src_base;
    assign rxf  = glitch ? 1'b0 : ((pos >= src_n) ? 1'b1 : 1'b0);
    assign data = (pos < src_n) ? src[pos[3:0]] : 8'hFF;

    usb_rx_packer dut (
        .clk(clk), .reset(reset), .data(data), .rxf(rxf), .rd(rd), .flush(flush),
        .out_data(out_data), .out_bytes(out_bytes), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .state(state)
    );

    usb_rx_packer #(.LITTLE_ENDIAN(0)) dut_be (
        .clk(clk), .reset(reset), .data(data), .rxf(rxf), .rd(be_rd), .flush(flush),
        .out_data(be_out_data), .out_bytes(be_out_bytes), .out_valid(be_out_valid),
        .out_ready(out_ready), .fifo_count(be_fifo_count), .state(be_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] low_mask, val_mask;
        logic [2:0]  st [40];
        logic [15:0] word_seen, be_word_seen;
        logic [1:0]  bytes_seen;
        logic        got, prev_rd, ever_low;
        int          falls;

        reset = 1'b0; flush = 1'b0; out_ready = 1'b1; glitch = 1'b0;
        src_n = 0; src_base = 0;
        for (int i = 0; i < 16; i++) src[i] = 8'h00;

        // Reset state
        tick(3);
        check("reset_rd", rd, 1);
        check("reset_valid", out_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_state", state, 0);
        check("reset_data", {out_bytes, out_data}, 0);
        reset = 1'b1;
        tick(2);
        check("idle_after_reset", state, 0);

        // Two bytes, little- and big-endian packing, strobe timing
        src[0] = 8'h34; src[1] = 8'h12; src_n = 2; src_base = rd_rises;
        low_mask = '0; val_mask = '0; word_seen = '0; be_word_seen = '0; bytes_seen = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            low_mask[i] = ~rd;
            val_mask[i] = out_valid;
            st[i] = state;
            if (out_valid) begin
                word_seen = out_data;
                bytes_seen = out_bytes;
            end
            if (be_out_valid) be_word_seen = be_out_data;
        end
        check("rd_low_pattern", low_mask, 64'h1E1E);
        check("valid_pattern", val_mask, 64'h2000);
        check("le_word", word_seen, 16'h1234);
        check("le_bytes", bytes_seen, 2);
        check("be_word", be_word_seen, 16'h3412);
        check("state_qual", st[0], 1);
        check("state_sample", st[4], 3);
        check("state_prechg", st[5], 4);
        check("state_idle_after_prechg", st[7], 0);

        // Single-cycle rxf glitch never starts a read
        src_n = 0; src_base = rd_rises;
        glitch = 1'b1;
        tick(1);
        check("glitch_qual", state, 1);
        glitch = 1'b0;
        ever_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rd) ever_low = 1'b1;
        end
        check("glitch_no_rd", ever_low, 0);
        check("glitch_idle", state, 0);

        // Back-pressure: 10 bytes available, only 4 words fit
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) src[i] = 8'(i + 1);
        src_n = 10; src_base = rd_rises;
        falls = 0; prev_rd = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (prev_rd && !rd) falls++;
            prev_rd = rd;
        end
        check("bp_falls", 64'(falls), 8);
        check("bp_count", fifo_count, 4);
        check("bp_rd_high", rd, 1);
        check("bp_state", state, 1);
        check("bp_head", out_data, 16'h0201);
        out_ready = 1'b1;
        check("drain0", out_data, 16'h0201);
        tick(1);
        check("drain1", {out_data, 5'(fifo_count)}, {16'h0403, 5'd3});
        tick(1);
        check("drain2", {out_data, 5'(fifo_count)}, {16'h0605, 5'd2});
        tick(1);
        check("drain3", {out_data, 5'(fifo_count)}, {16'h0807, 5'd1});
        tick(1);
        check("drain_empty", out_valid, 0);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("resume_seen", got, 1);
        check("resume_word", out_data, 16'h0A09);
        tick(1);

        // One byte then flush; second flush pushes nothing
        out_ready = 1'b0;
        src[0] = 8'hAB; src_n = 1; src_base = rd_rises;
        tick(20);
        check("partial_no_push", fifo_count, 0);
        check("partial_idle", state, 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        check("flush_valid", out_valid, 1);
        check("flush_word", out_data, 16'h00AB);
        check("flush_bytes", out_bytes, 1);
        check("flush_be_word", be_out_data, 16'hAB00);
        check("flush_be_bytes", be_out_bytes, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(3);
        check("flush2_count", fifo_count, 1);
        out_ready = 1'b1;
        tick(1);
        check("flush_popped", fifo_count, 0);

        // Reset during the second byte's strobe discards the partial word
        src[0] = 8'h55; src[1] = 8'h77; src_n = 2; src_base = rd_rises;
        tick(11);
        check("pre_reset_rd_low", rd, 0);
        reset = 1'b0;
        tick(1);
        check("mid_reset_rd", rd, 1);
        check("mid_reset_state", state, 0);
        reset = 1'b1;
        src[0] = 8'h01; src[1] = 8'h02; src_n = 2; src_base = rd_rises;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("post_reset_seen", got, 1);
        check("post_reset_word", out_data, 16'h0201);
        check("post_reset_bytes", out_bytes, 2);
        tick(2);
        check("post_reset_drained", fifo_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
